matmul_ctrl: RTL and testbench
==============================

Name: matmul_ctrl

Overview:
- Sequencing FSM for the systolic-array matmul datapath.
- On `start` it latches M/N/K and walks the tile loops: i over N/4, j over K/4, h over M+4 skewed rows.
- Each cycle it drives the datapath's address-mux selects, counter strobes, lane selects and memory read/write enables, so the datapath needs no control logic of its own.

Parameters:
- DIM, 4, systolic array edge; tile size and lanes per phase. Fixed at 4 in this revision.
- HW, 10, width of the h index; must hold M+3 for M up to 511.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; accepted only in IDLE
- M  in  9  rows of input matrix
- N  in  9  inner dimension; tile count b = N>>2
- K  in  9  output columns; tile count c = K>>2
- busy  out  1  high from BASE through DONE inclusive
- done  out  1  one-cycle pulse in DONE
- cfg_err  out  1  one-cycle pulse on rejected configuration
- base_cal  out  1  high in BASE; datapath registers bi1/bi2/bo
- i_cnt, j_cnt, h_cnt  out  1 each  index-advance strobes
- i_idx, j_idx  out  7 each  current tile indices
- h_idx  out  HW  current skewed row index
- sel_addr  out  2  00 weight addr, 01 input addr, 10 output addr, 11 idle
- wsub  out  4  weight offset within tile (bi2_sel)
- lane  out  2  drives w_sel / i_sel / fpo_sel for the current phase
- mem_rd  out  1  memory read enable
- mem_wr  out  1  memory write enable

Behaviour:
- Reset (async, any state):
  - state=IDLE; all strobes, enables, busy, done and cfg_err = 0.
  - Indices = 0; sel_addr=11; wsub=0; lane=0.
- IDLE:
  - start=1 with M==0, N<4 or K<4: pulse cfg_err next cycle, stay IDLE, no memory ops.
  - Otherwise latch M, b, c; go to BASE with i=j=0.
  - N[1:0] and K[1:0] are ignored (truncated).
- BASE (1 cycle): base_cal=1; h←0; sub←0.
- LOAD_W (16 cycles): sel_addr=00, mem_rd=1, wsub=sub, lane=sub[1:0]; sub increments 0..15, then ROW.
- ROW (decision only, zero-cycle): next is IN if h<M, else OUT if h≥4, else HSTEP.
- IN (4 cycles): sel_addr=01, mem_rd=1, lane=0..3. Then OUT if h≥4, else HSTEP.
- OUT (8 cycles): per lane L=0..3:
  - RD cycle: sel_addr=10, mem_rd=1, lane=L.
  - WR cycle: sel_addr=10, mem_wr=1, lane=L.
  - Then HSTEP.
- HSTEP (1 cycle): sel_addr=11.
  - If h<M+3: h_cnt=1, h+1, go to ROW.
  - Else if j<c-1: j_cnt=1, j+1, go to BASE.
  - Else if i<b-1: i_cnt=1, j←0, i+1, go to BASE.
  - Else: go to DONE.
- DONE (1 cycle): done=1, busy=1; then IDLE. Indices hold until the next start.
- Cycle accounting:
  - Per tile: 21+13·M cycles.
  - done asserts at cycle 1+b·c·(21+13M) after the cycle in which start is sampled.
- mem_rd and mem_wr are never high together.
- sel_addr=11 whenever both enables are low.
- start while busy: ignored; latched config unchanged.
- Reset mid-operation: immediate IDLE; no further enables.

Optional Feature:
- Macro MATMUL_CTRL_PERF_EN.
- Defined:
  - Adds output perf_cycles (32 bits), cleared on accepted start.
  - Increments every cycle while busy; holds after DONE; reset to 0.
  - Adds output perf_mem_ops (24 bits), counting cycles with mem_rd|mem_wr.
- Undefined: neither port exists; no counters are synthesized.

Test Plan:
- Reset check: assert rst_n=0 mid-LOAD_W → same cycle busy=0, mem_rd=0, sel_addr=11, state IDLE. Release, then start works normally.
- M=1, N=4, K=4, start at cycle 0:
  - base_cal at cycle 1; mem_rd with sel_addr=00 over cycles 2–17, wsub 0..15.
  - done at cycle 35.
  - Exactly 4 mem_wr pulses, lanes 0,1,2,3.
- M=2, N=8, K=8:
  - done at cycle 189.
  - j_cnt pulses 2 times, i_cnt 1 time.
  - Tile order (i,j) = (0,0),(0,1),(1,0),(1,1).
- M=0 or N=3: start → cfg_err pulse next cycle; busy, mem_rd and mem_wr stay 0.
- start re-pulsed during busy with different M: total cycle count and done cycle unchanged.
- MATMUL_CTRL_PERF_EN, M=1, N=K=4: perf_cycles=35; perf_mem_ops = 16+4+8 = 28.

Source files
------------

// File: rtl/matmul_ctrl.sv
// matmul_ctrl: sequencing FSM for the systolic-array matmul datapath.
//
// On an accepted start the block latches M, b = N>>2 and c = K>>2 and walks
// the tile loops (i over b, j over c, h over M+4 skewed rows).  Every cycle it
// drives the address-mux select, index strobes, lane/weight selects and the
// memory enables, so the datapath carries no control logic of its own.
//
// Optional feature: define MATMUL_CTRL_PERF_EN to add the perf_cycles_o and
// perf_mem_ops_o counters.  Without the macro neither port nor counter exists.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start_i           start pulse, accepted only in IDLE
//   M_i, N_i, K_i     matrix dimensions (N, K low two bits are ignored)
//   busy_o            high from BASE through DONE
//   done_o            one-cycle pulse in DONE
//   cfg_err_o         one-cycle pulse after a rejected start
//   base_cal_o        high in BASE (datapath registers base addresses)
//   i_cnt_o, j_cnt_o, h_cnt_o   index-advance strobes
//   i_idx_o, j_idx_o, h_idx_o   current tile / skewed-row indices
//   sel_addr_o        00 weight, 01 input, 10 output, 11 idle
//   wsub_o            weight offset within the tile
//   lane_o            lane select for the current phase
//   mem_rd_o, mem_wr_o  memory read / write enables
//   perf_cycles_o, perf_mem_ops_o  (MATMUL_CTRL_PERF_EN only)

module matmul_ctrl #(
  parameter int DIM = 4,
  parameter int HW  = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [8:0]    M_i,
  input  logic [8:0]    N_i,
  input  logic [8:0]    K_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          cfg_err_o,
  output logic          base_cal_o,
  output logic          i_cnt_o,
  output logic          j_cnt_o,
  output logic          h_cnt_o,
  output logic [6:0]    i_idx_o,
  output logic [6:0]    j_idx_o,
  output logic [HW-1:0] h_idx_o,
  output logic [1:0]    sel_addr_o,
  output logic [3:0]    wsub_o,
  output logic [1:0]    lane_o,
  output logic          mem_rd_o,
`ifdef MATMUL_CTRL_PERF_EN
  output logic          mem_wr_o,
  output logic [31:0]   perf_cycles_o,
  output logic [23:0]   perf_mem_ops_o
`else
  output logic          mem_wr_o
`endif
);

  localparam int LoadCycles = DIM * DIM;
  localparam int InCycles   = DIM;
  localparam int OutCycles  = 2 * DIM;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BASE,
    S_LOAD_W,
    S_IN,
    S_OUT,
    S_HSTEP,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [8:0]      m_q;
  logic [6:0]      b_q, c_q;
  logic [6:0]      i_q, j_q;
  logic [HW-1:0]   h_q;
  logic            cfg_err_q;

  logic            cfgBad;
  logic            accept;
  logic            hLast, jLast, iLast;
  logic [HW-1:0]   hNext;

  // ROW is a pure decision with no cycle of its own, so it is folded into the
  // transitions that would enter it.
  function automatic state_e rowDecision(input logic [HW-1:0] h, input logic [8:0] m);
    if (h < HW'(m))        return S_IN;
    else if (h >= HW'(DIM)) return S_OUT;
    else                   return S_HSTEP;
  endfunction

  assign cfgBad = (M_i == 9'd0) || (N_i < 9'd4) || (K_i < 9'd4);
  assign accept = (state_q == S_IDLE) && start_i && !cfgBad;
  assign hNext  = h_q + HW'(1);
  assign hLast  = (h_q >= (HW'(m_q) + HW'(3)));
  // j+1 >= c avoids underflow of c-1 (c is at least 1 here).
  assign jLast  = ({1'b0, j_q} + 8'd1) >= {1'b0, c_q};
  assign iLast  = ({1'b0, i_q} + 8'd1) >= {1'b0, b_q};

  // State register and phase counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept) state_d = S_BASE;
      S_BASE:   state_d = S_LOAD_W;
      S_LOAD_W: if (cnt_q == 4'(LoadCycles - 1)) state_d = rowDecision(h_q, m_q);
      S_IN:     if (cnt_q == 4'(InCycles - 1))
                  state_d = (h_q >= HW'(DIM)) ? S_OUT : S_HSTEP;
      S_OUT:    if (cnt_q == 4'(OutCycles - 1)) state_d = S_HSTEP;
      S_HSTEP: begin
        if (!hLast)                state_d = rowDecision(hNext, m_q);
        else if (!jLast || !iLast) state_d = S_BASE;
        else                       state_d = S_DONE;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // The phase counter restarts on every state change; HSTEP self-loops let it
  // run freely but nothing reads it there.
  always_comb begin
    cnt_d = (state_d != state_q) ? 4'd0 : cnt_q + 4'd1;
  end

  // Loop indices and latched configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q       <= 9'd0;
      b_q       <= 7'd0;
      c_q       <= 7'd0;
      i_q       <= 7'd0;
      j_q       <= 7'd0;
      h_q       <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= (state_q == S_IDLE) && start_i && cfgBad;
      if (accept) begin
        m_q <= M_i;
        b_q <= N_i[8:2];
        c_q <= K_i[8:2];
        i_q <= 7'd0;
        j_q <= 7'd0;
        h_q <= '0;
      end else if (state_q == S_BASE) begin
        h_q <= '0;
      end else if (state_q == S_HSTEP) begin
        if (!hLast) begin
          h_q <= hNext;
        end else if (!jLast) begin
          j_q <= j_q + 7'd1;
        end else if (!iLast) begin
          i_q <= i_q + 7'd1;
          j_q <= 7'd0;
        end
      end
    end
  end

  // Output decode.  In OUT the counter's LSB alternates read/write and the
  // upper bits pick the lane.
  always_comb begin
    busy_o     = 1'b1;
    done_o     = 1'b0;
    base_cal_o = 1'b0;
    i_cnt_o    = 1'b0;
    j_cnt_o    = 1'b0;
    h_cnt_o    = 1'b0;
    sel_addr_o = 2'b11;
    wsub_o     = 4'd0;
    lane_o     = 2'd0;
    mem_rd_o   = 1'b0;
    mem_wr_o   = 1'b0;
    unique case (state_q)
      S_IDLE:   busy_o = 1'b0;
      S_BASE:   base_cal_o = 1'b1;
      S_LOAD_W: begin
        sel_addr_o = 2'b00;
        mem_rd_o   = 1'b1;
        wsub_o     = cnt_q;
        lane_o     = cnt_q[1:0];
      end
      S_IN: begin
        sel_addr_o = 2'b01;
        mem_rd_o   = 1'b1;
        lane_o     = cnt_q[1:0];
      end
      S_OUT: begin
        sel_addr_o = 2'b10;
        lane_o     = cnt_q[2:1];
        mem_rd_o   = ~cnt_q[0];
        mem_wr_o   = cnt_q[0];
      end
      S_HSTEP: begin
        h_cnt_o = !hLast;
        j_cnt_o = hLast && !jLast;
        i_cnt_o = hLast && jLast && !iLast;
      end
      S_DONE:   done_o = 1'b1;
      default:  busy_o = 1'b0;
    endcase
  end

  assign cfg_err_o = cfg_err_q;
  assign i_idx_o   = i_q;
  assign j_idx_o   = j_q;
  assign h_idx_o   = h_q;

`ifdef MATMUL_CTRL_PERF_EN
  logic [31:0] perfCycles_q;
  logic [23:0] perfMemOps_q;

  // Both counters restart on an accepted start and hold once the run is over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perfCycles_q <= 32'd0;
      perfMemOps_q <= 24'd0;
    end else if (accept) begin
      perfCycles_q <= 32'd0;
      perfMemOps_q <= 24'd0;
    end else begin
      if (busy_o)              perfCycles_q <= perfCycles_q + 32'd1;
      if (mem_rd_o | mem_wr_o) perfMemOps_q <= perfMemOps_q + 24'd1;
    end
  end

  assign perf_cycles_o  = perfCycles_q;
  assign perf_mem_ops_o = perfMemOps_q;
`endif

endmodule

// File: tb/tb_matmul_ctrl.sv
// tb_matmul_ctrl: self-checking bench for matmul_ctrl.  Expected per-cycle
// control vectors come from nested tile/row/lane loops written straight from
// the sequencing rules; totals are checked against closed-form cycle formulas.

module tb_matmul_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [8:0]  M_i, N_i, K_i;
  logic        busy_o, done_o, cfg_err_o, base_cal_o;
  logic        i_cnt_o, j_cnt_o, h_cnt_o;
  logic [6:0]  i_idx_o, j_idx_o;
  logic [9:0]  h_idx_o;
  logic [1:0]  sel_addr_o;
  logic [3:0]  wsub_o;
  logic [1:0]  lane_o;
  logic        mem_rd_o, mem_wr_o;
`ifdef MATMUL_CTRL_PERF_EN
  logic [31:0] perf_cycles_o;
  logic [23:0] perf_mem_ops_o;
`endif

  int compareCount  = 0;
  int mismatchCount = 0;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       base;
    logic [1:0] sel;
    logic       rd;
    logic       wr;
    logic [1:0] lane;
    logic [3:0] wsub;
    logic       ic;
    logic       jc;
    logic       hc;
    logic [6:0] i;
    logic [6:0] j;
  } ctl_t;

  ctl_t expQ[$];
  int   expH[$];
  bit   hChk[$];

  matmul_ctrl #(.DIM(4), .HW(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .M_i        (M_i),
    .N_i        (N_i),
    .K_i        (K_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .cfg_err_o  (cfg_err_o),
    .base_cal_o (base_cal_o),
    .i_cnt_o    (i_cnt_o),
    .j_cnt_o    (j_cnt_o),
    .h_cnt_o    (h_cnt_o),
    .i_idx_o    (i_idx_o),
    .j_idx_o    (j_idx_o),
    .h_idx_o    (h_idx_o),
    .sel_addr_o (sel_addr_o),
    .wsub_o     (wsub_o),
    .lane_o     (lane_o),
    .mem_rd_o   (mem_rd_o),
`ifdef MATMUL_CTRL_PERF_EN
    .mem_wr_o       (mem_wr_o),
    .perf_cycles_o  (perf_cycles_o),
    .perf_mem_ops_o (perf_mem_ops_o)
`else
    .mem_wr_o   (mem_wr_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compareCount++;
    assert (obs === expv) else begin
      mismatchCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic ctl_t makeCtl(input int sel, input int rd, input int wr, input int lane,
                                   input int wsub, input int ic, input int jc, input int hc,
                                   input int i, input int j, input int base, input int done);
    ctl_t c;
    c.busy = 1'b1;
    c.done = 1'(done);
    c.base = 1'(base);
    c.sel  = 2'(sel);
    c.rd   = 1'(rd);
    c.wr   = 1'(wr);
    c.lane = 2'(lane);
    c.wsub = 4'(wsub);
    c.ic   = 1'(ic);
    c.jc   = 1'(jc);
    c.hc   = 1'(hc);
    c.i    = 7'(i);
    c.j    = 7'(j);
    return c;
  endfunction

  function automatic void pushCycle(input ctl_t c, input int h, input bit chk);
    expQ.push_back(c);
    expH.push_back(h);
    hChk.push_back(chk);
  endfunction

  // Expected schedule: for every tile a BASE cycle, 16 weight loads, then
  // for each skewed row h an input phase (h<M), an output phase (h>=4) and a
  // step cycle.  The h index is not checked in BASE, where it is being reset.
  function automatic void buildModel(input int m, input int b, input int c);
    expQ.delete();
    expH.delete();
    hChk.delete();
    for (int i = 0; i < b; i++) begin
      for (int j = 0; j < c; j++) begin
        pushCycle(makeCtl(3, 0, 0, 0, 0, 0, 0, 0, i, j, 1, 0), 0, 1'b0);
        for (int s = 0; s < 16; s++)
          pushCycle(makeCtl(0, 1, 0, s % 4, s, 0, 0, 0, i, j, 0, 0), 0, 1'b1);
        for (int h = 0; h <= m + 3; h++) begin
          if (h < m)
            for (int l = 0; l < 4; l++)
              pushCycle(makeCtl(1, 1, 0, l, 0, 0, 0, 0, i, j, 0, 0), h, 1'b1);
          if (h >= 4)
            for (int l = 0; l < 4; l++) begin
              pushCycle(makeCtl(2, 1, 0, l, 0, 0, 0, 0, i, j, 0, 0), h, 1'b1);
              pushCycle(makeCtl(2, 0, 1, l, 0, 0, 0, 0, i, j, 0, 0), h, 1'b1);
            end
          pushCycle(makeCtl(3, 0, 0, 0, 0,
                            int'(h == m + 3 && j == c - 1 && i < b - 1),
                            int'(h == m + 3 && j < c - 1),
                            int'(h < m + 3), i, j, 0, 0), h, 1'b1);
        end
      end
    end
    pushCycle(makeCtl(3, 0, 0, 0, 0, 0, 0, 0, b - 1, c - 1, 0, 1), m + 3, 1'b1);
  endfunction

  function automatic ctl_t observe();
    ctl_t o;
    o.busy = busy_o;
    o.done = done_o;
    o.base = base_cal_o;
    o.sel  = sel_addr_o;
    o.rd   = mem_rd_o;
    o.wr   = mem_wr_o;
    o.lane = lane_o;
    o.wsub = wsub_o;
    o.ic   = i_cnt_o;
    o.jc   = j_cnt_o;
    o.hc   = h_cnt_o;
    o.i    = i_idx_o;
    o.j    = j_idx_o;
    return o;
  endfunction

  // One full run; repulseAt > 0 pulses start with a different configuration
  // during that busy cycle, which must change nothing.
  task automatic applyStimulus(input int m, input int n, input int k, input int repulseAt);
    int b, c, doneCycle, wrCount, expDone;
    b = n / 4;
    c = k / 4;
    buildModel(m, b, c);
    expDone = 1 + b * c * (21 + 13 * m);
    doneCycle = 0;
    wrCount = 0;
    $display("[TB] run M=%0d N=%0d K=%0d repulse=%0d", m, n, k, repulseAt);
    @(negedge clk);
    start_i = 1'b1;
    M_i = 9'(m);
    N_i = 9'(n);
    K_i = 9'(k);
    for (int idx = 0; idx < expQ.size(); idx++) begin
      @(negedge clk);
      start_i = 1'b0;
      checkOutput($sformatf("ctl_cyc%0d", idx + 1), 64'(observe()), 64'(expQ[idx]));
      if (hChk[idx])
        checkOutput($sformatf("h_idx_cyc%0d", idx + 1), 64'(h_idx_o), 64'(expH[idx]));
      if (mem_rd_o && mem_wr_o)
        checkOutput("rd_wr_exclusive", 64'(1), 64'(0));
      if (done_o) doneCycle = idx + 1;
      if (mem_wr_o) wrCount++;
      if (idx + 1 == repulseAt) begin
        start_i = 1'b1;
        M_i = 9'(m + 5);
        N_i = 9'd12;
        K_i = 9'd16;
      end
    end
    checkOutput("done_cycle", 64'(doneCycle), 64'(expDone));
    checkOutput("wr_count", 64'(wrCount), 64'(b * c * 4 * m));
`ifdef MATMUL_CTRL_PERF_EN
    checkOutput("perf_cycles", 64'(perf_cycles_o), 64'(expDone));
    checkOutput("perf_mem_ops", 64'(perf_mem_ops_o), 64'(b * c * (16 + 12 * m)));
`endif
    @(negedge clk);
    start_i = 1'b0;
    checkOutput("idle_after_done", 64'({busy_o, done_o, mem_rd_o, mem_wr_o, sel_addr_o, i_idx_o, j_idx_o}),
                64'({1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 7'(b - 1), 7'(c - 1)}));
`ifdef MATMUL_CTRL_PERF_EN
    checkOutput("perf_hold", 64'(perf_cycles_o), 64'(expDone));
`endif
  endtask

  task automatic checkCfgErr(input int m, input int n, input int k);
    @(negedge clk);
    start_i = 1'b1;
    M_i = 9'(m);
    N_i = 9'(n);
    K_i = 9'(k);
    @(negedge clk);
    start_i = 1'b0;
    checkOutput($sformatf("cfg_err_pulse_M%0d_N%0d_K%0d", m, n, k),
                64'({cfg_err_o, busy_o, mem_rd_o, mem_wr_o}), 64'(4'b1000));
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      checkOutput("cfg_err_after", 64'({cfg_err_o, busy_o, mem_rd_o, mem_wr_o, sel_addr_o}),
                  64'(6'b000011));
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    start_i = 1'b0;
    M_i = 9'd0;
    N_i = 9'd0;
    K_i = 9'd0;
    #12;
    checkOutput("reset_state", 64'({busy_o, done_o, cfg_err_o, base_cal_o, i_cnt_o, j_cnt_o, h_cnt_o,
                                   mem_rd_o, mem_wr_o, sel_addr_o, wsub_o, lane_o,
                                   i_idx_o, j_idx_o, h_idx_o}),
                64'({9'b0, 2'b11, 4'd0, 2'd0, 7'd0, 7'd0, 10'd0}));
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1, 4, 4, 0);
    applyStimulus(2, 8, 8, 30);

    checkCfgErr(0, 8, 8);
    checkCfgErr(3, 3, 8);
    checkCfgErr(3, 8, 2);

    // Reset asserted in the middle of the weight load.
    @(negedge clk);
    start_i = 1'b1;
    M_i = 9'd1;
    N_i = 9'd4;
    K_i = 9'd4;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("pre_reset_loading", 64'({busy_o, mem_rd_o, sel_addr_o}), 64'(4'b1100));
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset", 64'({busy_o, mem_rd_o, mem_wr_o, done_o, base_cal_o, sel_addr_o, wsub_o, lane_o}),
                64'({5'b0, 2'b11, 4'd0, 2'd0}));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("after_reset_idle", 64'({busy_o, mem_rd_o, mem_wr_o, sel_addr_o}), 64'(5'b00011));
    applyStimulus(1, 4, 4, 3);

    for (int r = 0; r < 4; r++)
      applyStimulus(int'($urandom_range(1, 12)), int'($urandom_range(4, 15)),
                    int'($urandom_range(4, 15)), int'($urandom_range(2, 40)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
